// File: rtl/cpu_pkg.sv
// Shared constants for the multi-cycle 24-bit RISC CPU: widths, opcodes,
// instruction field positions and the control state encoding.
package cpu_pkg;

    localparam int unsigned CPU_DATA_W   = 24;
    localparam int unsigned CPU_ADDR_W   = 8;
    localparam int unsigned CPU_NREGS    = 8;
    localparam logic [7:0]  CPU_RESET_PC = 8'd0;

    localparam int unsigned OP_HI  = 23;
    localparam int unsigned OP_LO  = 20;
    localparam int unsigned RD_HI  = 19;
    localparam int unsigned RD_LO  = 17;
    localparam int unsigned RS1_HI = 16;
    localparam int unsigned RS1_LO = 14;
    localparam int unsigned RS2_HI = 13;
    localparam int unsigned RS2_LO = 11;
    localparam int unsigned IMM_HI = 13;
    localparam int unsigned IMM_LO = 0;

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_AND  = 4'd3;
    localparam logic [3:0] OP_OR   = 4'd4;
    localparam logic [3:0] OP_XOR  = 4'd5;
    localparam logic [3:0] OP_ADDI = 4'd6;
    localparam logic [3:0] OP_LW   = 4'd7;
    localparam logic [3:0] OP_SW   = 4'd8;
    localparam logic [3:0] OP_BEQ  = 4'd9;
    localparam logic [3:0] OP_BNE  = 4'd10;
    localparam logic [3:0] OP_JMP  = 4'd11;
    localparam logic [3:0] OP_HALT = 4'd15;

    typedef enum logic [2:0] {
        S_FETCH      = 3'd0,
        S_FETCH_WAIT = 3'd1,
        S_EXECUTE    = 3'd2,
        S_MEM        = 3'd3,
        S_MEM_WAIT   = 3'd4,
        S_HALT       = 3'd5
    } state_e;

    function automatic logic [CPU_DATA_W-1:0] sext_imm(input logic [13:0] imm);
        return {{10{imm[13]}}, imm};
    endfunction

endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU: arithmetic/logic result plus operand equality for branches.
module cpu_alu
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_W = CPU_DATA_W
) (
    input  logic [3:0]        op_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [DATA_W-1:0] result_o,
    output logic              eq_o
);

    // Operation select; address generation for LW/SW shares the adder.
    always_comb begin
        result_o = {DATA_W{1'b0}};
        case (op_i)
            OP_ADD, OP_ADDI, OP_LW, OP_SW: result_o = a_i + b_i;
            OP_SUB:                        result_o = a_i - b_i;
            OP_AND:                        result_o = a_i & b_i;
            OP_OR:                         result_o = a_i | b_i;
            OP_XOR:                        result_o = a_i ^ b_i;
            default:                       result_o = {DATA_W{1'b0}};
        endcase
    end

    assign eq_o = (a_i == b_i);

endmodule

// File: rtl/risc_cpu.sv
// Multi-cycle 24-bit RISC CPU sharing one synchronous memory for code and data.
// Each instruction walks FETCH -> FETCH_WAIT -> EXECUTE [-> MEM [-> MEM_WAIT]].
module risc_cpu
    import cpu_pkg::*;
#(
    parameter int unsigned       DATA_W   = CPU_DATA_W,
    parameter int unsigned       ADDR_W   = CPU_ADDR_W,
    parameter int unsigned       NREGS    = CPU_NREGS,
    parameter logic [ADDR_W-1:0] RESET_PC = CPU_RESET_PC
) (
    input  logic              clock,
    input  logic              reset,
    output logic [ADDR_W-1:0] MAR,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              Mem_EN,
    output logic              Mem_CS
);

    localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic [DATA_W-1:0] rf_q [NREGS];

    logic              rf_we_s;
    logic [2:0]        rf_waddr_s;
    logic [DATA_W-1:0] rf_wdata_s;

    logic [3:0]        op_s;
    logic [2:0]        rd_s, rs1_s, rs2_s;
    logic [DATA_W-1:0] imm_s;
    logic [DATA_W-1:0] rd_val_s, rs1_val_s, rs2_val_s;
    logic              is_branch_s, uses_imm_s;
    logic [DATA_W-1:0] alu_a_s, alu_b_s, alu_result_s;
    logic              alu_eq_s;

    assign op_s  = ir_q[OP_HI:OP_LO];
    assign rd_s  = ir_q[RD_HI:RD_LO];
    assign rs1_s = ir_q[RS1_HI:RS1_LO];
    assign rs2_s = ir_q[RS2_HI:RS2_LO];
    assign imm_s = sext_imm(ir_q[IMM_HI:IMM_LO]);

    // R0 is never written, but force zero on read so it holds even if it were.
    assign rd_val_s  = (rd_s  == 3'd0) ? {DATA_W{1'b0}} : rf_q[rd_s];
    assign rs1_val_s = (rs1_s == 3'd0) ? {DATA_W{1'b0}} : rf_q[rs1_s];
    assign rs2_val_s = (rs2_s == 3'd0) ? {DATA_W{1'b0}} : rf_q[rs2_s];

    // Branches compare rd against rs1; immediate forms replace rs2 with imm.
    assign is_branch_s = (op_s == OP_BEQ) || (op_s == OP_BNE);
    assign uses_imm_s  = (op_s == OP_ADDI) || (op_s == OP_LW) || (op_s == OP_SW);
    assign alu_a_s     = is_branch_s ? rd_val_s  : rs1_val_s;
    assign alu_b_s     = is_branch_s ? rs1_val_s : (uses_imm_s ? imm_s : rs2_val_s);

    cpu_alu #(.DATA_W(DATA_W)) u_alu (
        .op_i     (op_s),
        .a_i      (alu_a_s),
        .b_i      (alu_b_s),
        .result_o (alu_result_s),
        .eq_o     (alu_eq_s)
    );

    // Next-state, PC/IR/address updates and register write request.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        addr_d     = addr_q;
        dout_d     = dout_q;
        rf_we_s    = 1'b0;
        rf_waddr_s = rd_s;
        rf_wdata_s = alu_result_s;
        case (state_q)
            S_FETCH: begin
                state_d = S_FETCH_WAIT;
            end
            S_FETCH_WAIT: begin
                ir_d    = data_in;
                pc_d    = pc_q + PC_ONE;
                state_d = S_EXECUTE;
            end
            S_EXECUTE: begin
                state_d = S_FETCH;
                case (op_s)
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_ADDI: begin
                        rf_we_s = 1'b1;
                    end
                    OP_LW: begin
                        addr_d  = alu_result_s[ADDR_W-1:0];
                        state_d = S_MEM;
                    end
                    OP_SW: begin
                        addr_d  = alu_result_s[ADDR_W-1:0];
                        dout_d  = rd_val_s;
                        state_d = S_MEM;
                    end
                    OP_BEQ: begin
                        if (alu_eq_s) begin
                            pc_d = pc_q + imm_s[ADDR_W-1:0];
                        end else begin
                            pc_d = pc_q;
                        end
                    end
                    OP_BNE: begin
                        if (!alu_eq_s) begin
                            pc_d = pc_q + imm_s[ADDR_W-1:0];
                        end else begin
                            pc_d = pc_q;
                        end
                    end
                    OP_JMP: begin
                        pc_d = ir_q[ADDR_W-1:0];
                    end
                    OP_HALT: begin
                        state_d = S_HALT;
                    end
                    default: begin
                        state_d = S_FETCH;
                    end
                endcase
            end
            S_MEM: begin
                if (op_s == OP_SW) begin
                    state_d = S_FETCH;
                end else begin
                    state_d = S_MEM_WAIT;
                end
            end
            S_MEM_WAIT: begin
                rf_we_s    = 1'b1;
                rf_wdata_s = data_in;
                state_d    = S_FETCH;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // Control and datapath registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
            addr_q  <= {ADDR_W{1'b0}};
            ir_q    <= {DATA_W{1'b0}};
            dout_q  <= {DATA_W{1'b0}};
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            ir_q    <= ir_d;
            dout_q  <= dout_d;
        end
    end

    // Register file; R0 is never written.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                rf_q[i] <= {DATA_W{1'b0}};
            end
        end else if (rf_we_s && (rf_waddr_s != 3'd0)) begin
            rf_q[rf_waddr_s] <= rf_wdata_s;
        end else begin
            rf_q[0] <= {DATA_W{1'b0}};
        end
    end

    // Bus outputs depend only on state and registers; reset blocks any access.
    assign MAR      = (state_q == S_MEM) ? addr_q : pc_q;
    assign data_out = dout_q;
    assign Mem_CS   = !reset && ((state_q == S_FETCH) || (state_q == S_MEM));
    assign Mem_EN   = !reset && (state_q == S_MEM) && (op_s == OP_SW);

endmodule

// File: tb/tb_risc_cpu.sv
// Directed bench for risc_cpu: a behavioural 256x24 memory plus per-feature
// tasks that compare the bus access trace and memory contents to hand values.
module tb_risc_cpu;

    typedef struct packed {
        logic [15:0] cyc;
        logic [7:0]  mar;
        logic        en;
        logic [23:0] dat;
    } acc_t;

    logic        clock;
    logic        reset;
    logic [7:0]  MAR;
    logic [23:0] data_in;
    logic [23:0] data_out;
    logic        Mem_EN;
    logic        Mem_CS;

    logic        clr;
    logic        ld_en;
    logic [7:0]  ld_addr;
    logic [23:0] ld_data;
    logic [23:0] mem [256];

    int checks;
    int errors;
    int idle;
    acc_t tr[$];
    acc_t ex[$];
    logic [7:0]  p_addr[$];
    logic [23:0] p_data[$];

    risc_cpu dut (
        .clock    (clock),
        .reset    (reset),
        .MAR      (MAR),
        .data_in  (data_in),
        .data_out (data_out),
        .Mem_EN   (Mem_EN),
        .Mem_CS   (Mem_CS)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (clr) begin
            for (int i = 0; i < 256; i++) mem[i] <= 24'd0;
        end else if (ld_en) begin
            mem[ld_addr] <= ld_data;
        end else if (Mem_CS) begin
            if (Mem_EN) mem[MAR] <= data_out;
            else        data_in  <= mem[MAR];
        end
    end

    function automatic logic [23:0] enc(input logic [3:0] op, input logic [2:0] rd,
                                        input logic [2:0] rs1, input logic [13:0] imm);
        return {op, rd, rs1, imm};
    endfunction

    function automatic acc_t mk(input int cyc, input int mar, input logic en, input logic [23:0] dat);
        acc_t a;
        a.cyc = cyc[15:0];
        a.mar = mar[7:0];
        a.en  = en;
        a.dat = dat;
        return a;
    endfunction

    task automatic prog(input int addr, input logic [23:0] word);
        p_addr.push_back(addr[7:0]);
        p_data.push_back(word);
    endtask

    // Hold reset, clear and load memory, then release reset on a falling edge.
    task automatic start();
        reset = 1'b1;
        @(negedge clock); clr = 1'b1;
        @(negedge clock); clr = 1'b0;
        for (int i = 0; i < p_addr.size(); i++) begin
            ld_en = 1'b1; ld_addr = p_addr[i]; ld_data = p_data[i];
            @(negedge clock);
        end
        ld_en = 1'b0;
        p_addr.delete();
        p_data.delete();
        @(negedge clock);
        reset = 1'b0;
        #1;
    endtask

    task automatic sample(input int cyc);
        if (Mem_CS) begin
            tr.push_back(mk(cyc, int'(MAR), Mem_EN, Mem_EN ? data_out : 24'd0));
            idle = 0;
        end else begin
            idle++;
        end
    endtask

    task automatic run(input string name, input int max_cyc, input bit stop_on_halt);
        int cyc;
        tr.delete();
        idle = 0;
        cyc  = 0;
        sample(0);
        while (cyc < max_cyc && !(stop_on_halt && idle >= 8)) begin
            @(posedge clock); #1;
            cyc++;
            sample(cyc);
        end
        if (stop_on_halt) begin
            checks++;
            if (idle < 8) begin
                errors++;
                $display("FAIL %s_halt_timeout got no halt within %0d cycles, required halt", name, max_cyc);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        checks++;
        if (Mem_CS !== 1'b0 || Mem_EN !== 1'b0) begin
            errors++;
            $display("FAIL reset_cs_en got cs=%b en=%b, required 0 0", Mem_CS, Mem_EN);
        end
        checks++;
        if (MAR !== 8'd0 || data_out !== 24'd0) begin
            errors++;
            $display("FAIL reset_mar_dout got mar=%0d dout=%h, required 0 000000", MAR, data_out);
        end
    endtask

    task automatic test_alu();
        prog(0, enc(4'd6, 3'd1, 3'd0, 14'd5));
        prog(1, enc(4'd6, 3'd2, 3'd0, 14'h3FFD));
        prog(2, {4'd1, 3'd3, 3'd1, 3'd2, 11'd0});
        prog(3, enc(4'd8, 3'd3, 3'd0, 14'd100));
        prog(4, enc(4'd8, 3'd2, 3'd0, 14'd101));
        prog(5, {4'd15, 20'd0});
        start();
        run("alu", 200, 1'b1);
        ex.delete();
        ex.push_back(mk(0, 0, 1'b0, 24'd0));
        ex.push_back(mk(3, 1, 1'b0, 24'd0));
        ex.push_back(mk(6, 2, 1'b0, 24'd0));
        ex.push_back(mk(9, 3, 1'b0, 24'd0));
        ex.push_back(mk(12, 100, 1'b1, 24'd2));
        ex.push_back(mk(13, 4, 1'b0, 24'd0));
        ex.push_back(mk(16, 101, 1'b1, 24'hFFFFFD));
        ex.push_back(mk(17, 5, 1'b0, 24'd0));
        checks++;
        if (tr.size() != ex.size()) begin
            errors++;
            $display("FAIL alu_trace_len got %0d, required %0d", tr.size(), ex.size());
        end
        for (int i = 0; i < tr.size() && i < ex.size(); i++) begin
            checks++;
            if (tr[i] !== ex[i]) begin
                errors++;
                $display("FAIL alu_trace[%0d] got cyc=%0d mar=%0d en=%b dat=%h, required cyc=%0d mar=%0d en=%b dat=%h",
                         i, tr[i].cyc, tr[i].mar, tr[i].en, tr[i].dat, ex[i].cyc, ex[i].mar, ex[i].en, ex[i].dat);
            end
        end
        checks++;
        if (mem[100] !== 24'd2 || mem[101] !== 24'hFFFFFD) begin
            errors++;
            $display("FAIL alu_results got r3=%h r2=%h, required 000002 fffffd", mem[100], mem[101]);
        end
        begin
            int cs_seen = 0;
            repeat (10) begin
                @(posedge clock); #1;
                if (Mem_CS !== 1'b0) cs_seen++;
            end
            checks++;
            if (cs_seen != 0) begin
                errors++;
                $display("FAIL alu_halt_cs got %0d cycles with cs=1, required 0", cs_seen);
            end
        end
    endtask

    task automatic test_load_store();
        prog(50, 24'h123456);
        prog(0, enc(4'd7, 3'd1, 3'd0, 14'd50));
        prog(1, enc(4'd8, 3'd1, 3'd0, 14'd40));
        prog(2, enc(4'd7, 3'd4, 3'd0, 14'd40));
        prog(3, enc(4'd8, 3'd4, 3'd0, 14'd41));
        prog(4, {4'd15, 20'd0});
        start();
        run("ldst", 200, 1'b1);
        ex.delete();
        ex.push_back(mk(0, 0, 1'b0, 24'd0));
        ex.push_back(mk(3, 50, 1'b0, 24'd0));
        ex.push_back(mk(5, 1, 1'b0, 24'd0));
        ex.push_back(mk(8, 40, 1'b1, 24'h123456));
        ex.push_back(mk(9, 2, 1'b0, 24'd0));
        ex.push_back(mk(12, 40, 1'b0, 24'd0));
        ex.push_back(mk(14, 3, 1'b0, 24'd0));
        ex.push_back(mk(17, 41, 1'b1, 24'h123456));
        ex.push_back(mk(18, 4, 1'b0, 24'd0));
        checks++;
        if (tr.size() != ex.size()) begin
            errors++;
            $display("FAIL ldst_trace_len got %0d, required %0d", tr.size(), ex.size());
        end
        for (int i = 0; i < tr.size() && i < ex.size(); i++) begin
            checks++;
            if (tr[i] !== ex[i]) begin
                errors++;
                $display("FAIL ldst_trace[%0d] got cyc=%0d mar=%0d en=%b dat=%h, required cyc=%0d mar=%0d en=%b dat=%h",
                         i, tr[i].cyc, tr[i].mar, tr[i].en, tr[i].dat, ex[i].cyc, ex[i].mar, ex[i].en, ex[i].dat);
            end
        end
        checks++;
        if (mem[40] !== 24'h123456 || mem[41] !== 24'h123456) begin
            errors++;
            $display("FAIL ldst_mem got m40=%h m41=%h, required 123456 123456", mem[40], mem[41]);
        end
    endtask

    task automatic test_branch();
        prog(0,  {4'd11, 20'd5});
        prog(5,  enc(4'd9,  3'd0, 3'd0, 14'd2));
        prog(8,  enc(4'd6,  3'd1, 3'd0, 14'd1));
        prog(9,  enc(4'd10, 3'd1, 3'd1, 14'd3));
        prog(10, enc(4'd10, 3'd1, 3'd0, 14'd2));
        prog(13, {4'd15, 20'd0});
        start();
        run("branch", 200, 1'b1);
        ex.delete();
        ex.push_back(mk(0, 0, 1'b0, 24'd0));
        ex.push_back(mk(3, 5, 1'b0, 24'd0));
        ex.push_back(mk(6, 8, 1'b0, 24'd0));
        ex.push_back(mk(9, 9, 1'b0, 24'd0));
        ex.push_back(mk(12, 10, 1'b0, 24'd0));
        ex.push_back(mk(15, 13, 1'b0, 24'd0));
        checks++;
        if (tr.size() != ex.size()) begin
            errors++;
            $display("FAIL branch_trace_len got %0d, required %0d", tr.size(), ex.size());
        end
        for (int i = 0; i < tr.size() && i < ex.size(); i++) begin
            checks++;
            if (tr[i] !== ex[i]) begin
                errors++;
                $display("FAIL branch_trace[%0d] got cyc=%0d mar=%0d en=%b, required cyc=%0d mar=%0d en=%b",
                         i, tr[i].cyc, tr[i].mar, tr[i].en, ex[i].cyc, ex[i].mar, ex[i].en);
            end
        end
    endtask

    task automatic test_wrap();
        prog(0,   enc(4'd6, 3'd1, 3'd0, 14'd1));
        prog(1,   {4'd11, 20'd250});
        prog(250, enc(4'd9, 3'd0, 3'd0, 14'd10));
        prog(5,   {4'd11, 20'd255});
        prog(255, 24'd0);
        start();
        run("wrap", 15, 1'b0);
        ex.delete();
        ex.push_back(mk(0, 0, 1'b0, 24'd0));
        ex.push_back(mk(3, 1, 1'b0, 24'd0));
        ex.push_back(mk(6, 250, 1'b0, 24'd0));
        ex.push_back(mk(9, 5, 1'b0, 24'd0));
        ex.push_back(mk(12, 255, 1'b0, 24'd0));
        ex.push_back(mk(15, 0, 1'b0, 24'd0));
        checks++;
        if (tr.size() != ex.size()) begin
            errors++;
            $display("FAIL wrap_trace_len got %0d, required %0d", tr.size(), ex.size());
        end
        for (int i = 0; i < tr.size() && i < ex.size(); i++) begin
            checks++;
            if (tr[i] !== ex[i]) begin
                errors++;
                $display("FAIL wrap_trace[%0d] got cyc=%0d mar=%0d en=%b, required cyc=%0d mar=%0d en=%b",
                         i, tr[i].cyc, tr[i].mar, tr[i].en, ex[i].cyc, ex[i].mar, ex[i].en);
            end
        end
    endtask

    task automatic test_r0_illegal();
        prog(60, 24'hABCDEF);
        prog(61, 24'hABCDEF);
        prog(0, enc(4'd6, 3'd0, 3'd0, 14'd7));
        prog(1, enc(4'd13, 3'd1, 3'd0, 14'd5));
        prog(2, enc(4'd8, 3'd0, 3'd0, 14'd60));
        prog(3, enc(4'd8, 3'd1, 3'd0, 14'd61));
        prog(4, {4'd15, 20'd0});
        start();
        run("r0", 200, 1'b1);
        ex.delete();
        ex.push_back(mk(0, 0, 1'b0, 24'd0));
        ex.push_back(mk(3, 1, 1'b0, 24'd0));
        ex.push_back(mk(6, 2, 1'b0, 24'd0));
        ex.push_back(mk(9, 60, 1'b1, 24'd0));
        ex.push_back(mk(10, 3, 1'b0, 24'd0));
        ex.push_back(mk(13, 61, 1'b1, 24'd0));
        ex.push_back(mk(14, 4, 1'b0, 24'd0));
        checks++;
        if (tr.size() != ex.size()) begin
            errors++;
            $display("FAIL r0_trace_len got %0d, required %0d", tr.size(), ex.size());
        end
        for (int i = 0; i < tr.size() && i < ex.size(); i++) begin
            checks++;
            if (tr[i] !== ex[i]) begin
                errors++;
                $display("FAIL r0_trace[%0d] got cyc=%0d mar=%0d en=%b dat=%h, required cyc=%0d mar=%0d en=%b dat=%h",
                         i, tr[i].cyc, tr[i].mar, tr[i].en, tr[i].dat, ex[i].cyc, ex[i].mar, ex[i].en, ex[i].dat);
            end
        end
        checks++;
        if (mem[60] !== 24'd0 || mem[61] !== 24'd0) begin
            errors++;
            $display("FAIL r0_values got r0=%h r1=%h, required 000000 000000", mem[60], mem[61]);
        end
    endtask

    task automatic test_reset_mid_store();
        bit seen = 1'b0;
        prog(40, 24'h777777);
        prog(0, enc(4'd6, 3'd1, 3'd0, 14'd9));
        prog(1, enc(4'd8, 3'd1, 3'd0, 14'd40));
        prog(2, {4'd15, 20'd0});
        start();
        for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge clock); #1;
            if (Mem_CS === 1'b1 && Mem_EN === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL midrst_store_seen got none in 20 cycles, required a store access");
        end
        reset = 1'b1;
        #1;
        checks++;
        if (Mem_CS !== 1'b0 || Mem_EN !== 1'b0 || MAR !== 8'd0 || data_out !== 24'd0) begin
            errors++;
            $display("FAIL midrst_outputs got cs=%b en=%b mar=%0d dout=%h, required 0 0 0 000000",
                     Mem_CS, Mem_EN, MAR, data_out);
        end
        repeat (3) @(posedge clock);
        #1;
        checks++;
        if (mem[40] !== 24'h777777) begin
            errors++;
            $display("FAIL midrst_no_write got m40=%h, required 777777", mem[40]);
        end
        @(negedge clock);
        reset = 1'b0;
        #1;
        checks++;
        if (Mem_CS !== 1'b1 || Mem_EN !== 1'b0 || MAR !== 8'd0) begin
            errors++;
            $display("FAIL midrst_first_fetch got cs=%b en=%b mar=%0d, required 1 0 0", Mem_CS, Mem_EN, MAR);
        end
        run("midrst", 200, 1'b1);
        checks++;
        if (mem[40] !== 24'd9) begin
            errors++;
            $display("FAIL midrst_rerun got m40=%h, required 000009", mem[40]);
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        reset   = 1'b1;
        clr     = 1'b0;
        ld_en   = 1'b0;
        ld_addr = 8'd0;
        ld_data = 24'd0;
        test_reset();
        test_alu();
        test_load_store();
        test_branch();
        test_wrap();
        test_r0_illegal();
        test_reset_mid_store();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
